// File: rtl/app_mult_pkg.sv
// ============================================================================
// app_mult_pkg : shared types and width helpers for the iterative multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package app_mult_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int res_width(input int w1, input int w2);
        return w1 + w2;
    endfunction

    // Counter indexes bits 0..w2-1 of the multiplier; never narrower than 1 bit.
    function automatic int cnt_width(input int w2);
        return (w2 <= 2) ? 1 : $clog2(w2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/app_mult_pp_gen.sv
// ============================================================================
// app_mult_pp_gen : extended, shifted and low-column-masked partial product
// Rev 1.0
// ============================================================================
`default_nettype none

module app_mult_pp_gen
    import app_mult_pkg::*;
#(
    parameter int WIDTH1 = 8,
    parameter int WIDTH2 = 8,
    parameter int TRUNC  = 0
) (
    input  logic [WIDTH1-1:0]                     i_a,
    input  logic                                  i_signed,
    input  logic [cnt_width(WIDTH2)-1:0]          i_shift,
    output logic [res_width(WIDTH1, WIDTH2)-1:0]  o_pp
);

    localparam int            c_RW   = res_width(WIDTH1, WIDTH2);
    localparam logic [c_RW-1:0] c_MASK = {c_RW{1'b1}} << TRUNC;

    logic [c_RW-1:0] w_ext;

    assign w_ext = {{WIDTH2{i_signed & i_a[WIDTH1-1]}}, i_a};
    assign o_pp  = (w_ext << i_shift) & c_MASK;

endmodule

`default_nettype wire

// File: rtl/app_mult_iter.sv
// ============================================================================
// app_mult_iter : shift-add multiplier, one partial product per clock,
//                 computes A*B+cin with optional partial-product truncation.
// Rev 1.0
// ============================================================================
`default_nettype none

module app_mult_iter
    import app_mult_pkg::*;
#(
    parameter int WIDTH1 = 8,
    parameter int WIDTH2 = 8,
    parameter int TRUNC  = 0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       en,
    input  logic [WIDTH1-1:0]          A,
    input  logic [WIDTH2-1:0]          B,
    input  logic                       is_signed,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH1+WIDTH2-1:0]   sum
);

    localparam int              c_RW   = res_width(WIDTH1, WIDTH2);
    localparam int              c_CW   = cnt_width(WIDTH2);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH2 - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH1-1:0] r_a;
    logic [WIDTH2-1:0] r_b;
    logic              r_signed;
    logic [c_RW-1:0]   r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [c_RW-1:0]   r_sum;
    logic              r_done;

    logic [c_RW-1:0]   w_pp;
    logic [c_RW-1:0]   w_acc_nxt;
    logic              w_last;

    app_mult_pp_gen #(
        .WIDTH1 (WIDTH1),
        .WIDTH2 (WIDTH2),
        .TRUNC  (TRUNC)
    ) u_pp_gen (
        .i_a      (r_a),
        .i_signed (r_signed),
        .i_shift  (r_cnt),
        .o_pp     (w_pp)
    );

    assign w_last = (r_cnt == c_LAST);

    // The MSB of a two's-complement multiplier carries negative weight.
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_b[r_cnt]) begin
            if (w_last && r_signed) w_acc_nxt = r_acc - w_pp;
            else                    w_acc_nxt = r_acc + w_pp;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en)     w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = r_done;
        sum  = r_sum;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= is_signed;
                        r_acc    <= c_RW'(cin);
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_acc_nxt;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_app_mult_iter.sv
// ============================================================================
// tb_app_mult_iter : directed and random checks of app_mult_iter in four
//                    parameterisations sharing one stimulus bus.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_app_mult_iter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        sgn   = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a_in  = '0;
    logic [15:0] b_in  = '0;

    logic        busy_d, done_d, busy_t, done_t, busy_5, done_5, busy_w, done_w;
    logic [15:0] sum_d, sum_t;
    logic [12:0] sum_5;
    logic [31:0] sum_w;

    int n_tests = 0;
    int n_fail  = 0;
    int lat_d, lat_t, lat_5, lat_w, busy_cnt, done_cnt;
    logic [63:0] got_d, got_t, got_5, got_w;

    always #5 clk = ~clk;

    app_mult_iter #(.WIDTH1(8), .WIDTH2(8), .TRUNC(0)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .A(a_in[7:0]), .B(b_in[7:0]),
        .is_signed(sgn), .cin(cin), .busy(busy_d), .done(done_d), .sum(sum_d));

    app_mult_iter #(.WIDTH1(8), .WIDTH2(8), .TRUNC(4)) u_trc (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .A(a_in[7:0]), .B(b_in[7:0]),
        .is_signed(sgn), .cin(cin), .busy(busy_t), .done(done_t), .sum(sum_t));

    app_mult_iter #(.WIDTH1(8), .WIDTH2(5), .TRUNC(0)) u_w85 (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .A(a_in[7:0]), .B(b_in[4:0]),
        .is_signed(sgn), .cin(cin), .busy(busy_5), .done(done_5), .sum(sum_5));

    app_mult_iter #(.WIDTH1(16), .WIDTH2(16), .TRUNC(0)) u_w16 (
        .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .A(a_in), .B(b_in),
        .is_signed(sgn), .cin(cin), .busy(busy_w), .done(done_w), .sum(sum_w));

    // Reference: operands interpreted as integers, multiplied, wrapped to the result width.
    function automatic logic [63:0] exact(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input bit c, input int w1, input int w2);
        longint sa, sb;
        logic [63:0] m;
        sa = longint'(a & ((64'd1 << w1) - 1));
        sb = longint'(b & ((64'd1 << w2) - 1));
        if (s && a[w1-1]) sa = sa - (longint'(1) << w1);
        if (s && b[w2-1]) sb = sb - (longint'(1) << w2);
        m = (64'd1 << (w1 + w2)) - 1;
        return 64'(sa * sb + longint'(c)) & m;
    endfunction

    // Truncated reference: sum of the weighted operand copies with low columns dropped.
    function automatic logic [63:0] approx(input logic [63:0] a, input logic [63:0] b,
                                           input bit s, input bit c, input int w1, input int w2,
                                           input int t);
        logic [63:0] m, ae, pp, acc;
        m  = (64'd1 << (w1 + w2)) - 1;
        ae = a & ((64'd1 << w1) - 1);
        if (s && a[w1-1]) ae = ae | ~((64'd1 << w1) - 1);
        acc = 64'(c);
        for (int i = 0; i < w2; i++) begin
            if (b[i]) begin
                pp = (ae << i) & m & ~((64'd1 << t) - 1);
                if (s && i == w2 - 1) acc = acc - pp;
                else                  acc = acc + pp;
            end
        end
        return acc & m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] a, input logic [15:0] b, input bit s, input bit c);
        a_in = a; b_in = b; sgn = s; cin = c; en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    // One transaction on all instances; k counts edges after the capture edge.
    task automatic run(input logic [15:0] a, input logic [15:0] b, input bit s, input bit c,
                       input bit poke);
        lat_d = 0; lat_t = 0; lat_5 = 0; lat_w = 0; busy_cnt = 0; done_cnt = 0;
        got_d = '0; got_t = '0; got_5 = '0; got_w = '0;
        start(a, b, s, c);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            if (poke && k == 3) begin
                a_in = ~a; b_in = b + 16'd1; cin = ~c; sgn = ~s; en = 1'b1;
            end else begin
                en = 1'b0;
            end
            if (lat_d == 0 && busy_d) busy_cnt++;
            if (done_d && busy_d) busy_cnt += 100;
            if (done_d) begin
                done_cnt++;
                if (lat_d == 0) begin lat_d = k; got_d = 64'(sum_d); end
            end
            if (done_t && lat_t == 0) begin lat_t = k; got_t = 64'(sum_t); end
            if (done_5 && lat_5 == 0) begin lat_5 = k; got_5 = 64'(sum_5); end
            if (done_w && lat_w == 0) begin lat_w = k; got_w = 64'(sum_w); end
        end
        chk("lat_8x8",    64'(lat_d),    64'd8);
        chk("busy_8x8",   64'(busy_cnt), 64'd8);
        chk("done_pulse", 64'(done_cnt), 64'd1);
        chk("sum_8x8",    got_d, exact(64'(a), 64'(b), s, c, 8, 8));
        chk("lat_trunc",  64'(lat_t),    64'd8);
        chk("sum_trunc",  got_t, approx(64'(a), 64'(b), s, c, 8, 8, 4));
        chk("lat_8x5",    64'(lat_5),    64'd5);
        chk("sum_8x5",    got_5, exact(64'(a), 64'(b), s, c, 8, 5));
        chk("lat_16x16",  64'(lat_w),    64'd16);
        chk("sum_16x16",  got_w, exact(64'(a), 64'(b), s, c, 16, 16));
    endtask

    initial begin
        int k;
        // Reset with en held high: nothing may start.
        en = 1'b1; a_in = 16'd5; b_in = 16'd5;
        repeat (3) tick();
        chk("rst_busy", 64'(busy_d), 64'd0);
        chk("rst_done", 64'(done_d), 64'd0);
        chk("rst_sum",  64'(sum_d),  64'd0);
        en = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 64'(busy_d), 64'd0);

        run(16'd200, 16'd100, 1'b0, 1'b0, 1'b0);
        chk("u200x100", got_d, 64'h4E20);
        run(16'h0007, 16'h00FD, 1'b1, 1'b0, 1'b0);
        chk("s7xm3", got_d, 64'hFFEB);
        run(16'h0080, 16'h0080, 1'b1, 1'b0, 1'b0);
        chk("sm128xm128", got_d, 64'h4000);
        run(16'h00FB, 16'h00F9, 1'b1, 1'b1, 1'b0);
        chk("sm5xm7c1", got_d, 64'd36);
        run(16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        chk("cin_only", got_d, 64'd1);
        run(16'd15, 16'd15, 1'b0, 1'b0, 1'b0);
        chk("trunc4_15x15", got_t, 64'd176);
        chk("exact_15x15",  got_d, 64'd225);
        run(16'd37, 16'd91, 1'b0, 1'b0, 1'b1);
        chk("en_in_run_ignored", got_d, 64'd3367);

        // Back-to-back: en held in the done cycle starts the next transaction.
        start(16'd10, 16'd20, 1'b0, 1'b0);
        k = 0;
        while (!done_d && k < 20) begin tick(); k++; end
        chk("b2b_first", 64'(sum_d), 64'd200);
        a_in = 16'd11; b_in = 16'd12; en = 1'b1;
        tick();
        en = 1'b0;
        chk("b2b_accepted", 64'(busy_d), 64'd1);
        k = 0;
        while (!done_d && k < 20) begin tick(); k++; end
        chk("b2b_second", 64'(sum_d), 64'd132);
        repeat (20) tick();

        // Reset mid-RUN aborts without a done.
        start(16'd100, 16'd100, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_d), 64'd0);
        chk("abort_done", 64'(done_d), 64'd0);
        chk("abort_sum",  64'(sum_d),  64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (done_d) done_cnt++;
        end
        chk("no_done_after_abort", 64'(done_cnt), 64'd0);
        run(16'd3, 16'd4, 1'b0, 1'b0, 1'b0);
        chk("after_abort_3x4", got_d, 64'd12);

        for (int r = 0; r < 24; r++) begin
            run(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
